// File: rtl/exec_stage_mdu_if.sv
// exec_stage_mdu_if: ID/EX inputs, MEM/WB forwarding inputs and the
// registered EX/MEM outputs of the execute stage, plus the ready/busy
// handshake. master = upstream (pipeline/testbench), slave = exec stage.
interface exec_stage_mdu_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic [XLEN-1:0]    rs_data;
    logic [XLEN-1:0]    rt_data;
    logic [XLEN-1:0]    imm_ext;
    logic [7:0]         ctrl;
    logic               wb_reg_write;
    logic [RADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               out_valid;
    logic [XLEN-1:0]    out_result;
    logic [XLEN-1:0]    out_store_data;
    logic [RADDR_W-1:0] out_rd;
    logic               out_reg_write;
    logic               out_mem_read;
    logic               out_mem_to_reg;
    logic               out_mem_write;
    logic               out_zero;
    logic               out_ovf;
    logic               busy;

    modport master (
        output in_valid, instr, rs_data, rt_data, imm_ext, ctrl,
        output wb_reg_write, wb_rd, wb_data,
        input  in_ready, out_valid, out_result, out_store_data, out_rd,
        input  out_reg_write, out_mem_read, out_mem_to_reg,
        input  out_mem_write, out_zero, out_ovf, busy
    );

    modport slave (
        input  in_valid, instr, rs_data, rt_data, imm_ext, ctrl,
        input  wb_reg_write, wb_rd, wb_data,
        output in_ready, out_valid, out_result, out_store_data, out_rd,
        output out_reg_write, out_mem_read, out_mem_to_reg,
        output out_mem_write, out_zero, out_ovf, busy
    );
endinterface

// File: rtl/exec_stage_mdu.sv
// exec_stage_mdu: MIPS execute stage with EX/MEM + MEM/WB forwarding,
// registered EX/MEM outputs and an optional iterative signed mult/div unit.
// Ports: clk, rst (sync, active high), io (exec_stage_mdu_if.slave).
// Macro EXEC_MDU_EN enables the MDU, HI/LO, mfhi/mflo and the stall.
module exec_stage_mdu #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    exec_stage_mdu_if.slave io
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [5:0]         funct;
    logic [4:0]         shamt;
    logic [5:0]         unused_opcode;
    logic [RADDR_W-1:0] rs_a, rt_a, rd_a, dst;
    logic               reg_dst, mem_wr, mem_to_reg;
    logic               mem_rd, alu_src, reg_wr;
    logic [1:0]         alu_op;

    assign funct = io.instr[5:0];
    assign shamt = io.instr[10:6];
    assign rd_a  = RADDR_W'(io.instr[15:11]);
    assign rt_a  = RADDR_W'(io.instr[20:16]);
    assign rs_a  = RADDR_W'(io.instr[25:21]);
    assign unused_opcode = io.instr[31:26];
    assign {reg_dst, mem_wr, mem_to_reg, alu_op,
            mem_rd, alu_src, reg_wr} = io.ctrl;
    assign dst = reg_dst ? rd_a : rt_a;

    // EX/MEM output registers
    logic               valid_q, rw_q, mr_q, mtr_q, mw_q;
    logic               zero_q, ovf_q;
    logic [XLEN-1:0]    res_q, st_q;
    logic [RADDR_W-1:0] rd_q;

    // Forwarding: EX/MEM beats MEM/WB, register 0 never forwarded
    logic            ex_a, ex_b, wb_a, wb_b;
    logic [XLEN-1:0] fwd_a, fwd_b, op_b;

    assign ex_a = valid_q & rw_q & (rd_q != '0) & (rd_q == rs_a);
    assign ex_b = valid_q & rw_q & (rd_q != '0) & (rd_q == rt_a);
    assign wb_a = io.wb_reg_write & (io.wb_rd != '0)
                & (io.wb_rd == rs_a);
    assign wb_b = io.wb_reg_write & (io.wb_rd != '0)
                & (io.wb_rd == rt_a);
    assign fwd_a = ex_a ? res_q : (wb_a ? io.wb_data : io.rs_data);
    assign fwd_b = ex_b ? res_q : (wb_b ? io.wb_data : io.rt_data);
    assign op_b  = alu_src ? io.imm_ext : fwd_b;

    logic [XLEN-1:0] sum, dif, alu_res, hi_rd, lo_rd;
    logic            ovf_add, ovf_sub, slt, alu_ovf;
    logic            is_mul, is_div, mdu_op;
    logic            ready, acc;

    assign sum = fwd_a + op_b;
    assign dif = fwd_a - op_b;
    assign ovf_add = (fwd_a[XLEN-1] == op_b[XLEN-1])
                   & (sum[XLEN-1] != fwd_a[XLEN-1]);
    assign ovf_sub = (fwd_a[XLEN-1] != op_b[XLEN-1])
                   & (dif[XLEN-1] != fwd_a[XLEN-1]);
    assign slt = $signed(fwd_a) < $signed(op_b);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        unique case (alu_op)
            2'b00: begin
                alu_res = sum;
                alu_ovf = ovf_add;
            end
            2'b01: begin
                alu_res = dif;
                alu_ovf = ovf_sub;
            end
            2'b10: begin
                case (funct)
                    6'h20: begin
                        alu_res = sum;
                        alu_ovf = ovf_add;
                    end
                    6'h22: begin
                        alu_res = dif;
                        alu_ovf = ovf_sub;
                    end
                    6'h24: alu_res = fwd_a & op_b;
                    6'h25: alu_res = fwd_a | op_b;
                    6'h27: alu_res = ~(fwd_a | op_b);
                    6'h2A: alu_res = XLEN'(slt);
                    6'h00: alu_res = op_b << shamt;
                    6'h02: alu_res = op_b >> shamt;
                    6'h10: alu_res = hi_rd;
                    6'h12: alu_res = lo_rd;
                    6'h18: is_mul = 1'b1;
                    6'h1A: is_div = 1'b1;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    assign mdu_op = is_mul | is_div;
    assign acc    = io.in_valid & ready;

`ifdef EXEC_MDU_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [2*XLEN-1:0] work_q, work_d, prod_s;
    logic [XLEN-1:0]   mag_q, mag_d, dvd_q, dvd_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]   mag_a, mag_b, rem_n;
    logic              neg_q, neg_d;
    logic [XLEN:0]     mul_sum, div_sh, div_sub;

    assign mag_a = fwd_a[XLEN-1] ? -fwd_a : fwd_a;
    assign mag_b = fwd_b[XLEN-1] ? -fwd_b : fwd_b;
    assign mul_sum = {1'b0, work_q[2*XLEN-1:XLEN]}
                   + (work_q[0] ? {1'b0, mag_q} : '0);
    assign div_sh  = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    assign div_sub = div_sh - {1'b0, mag_q};
    // borrow out of the trial subtraction means "does not fit"
    assign rem_n   = div_sub[XLEN] ? div_sh[XLEN-1:0]
                                   : div_sub[XLEN-1:0];
    assign prod_s  = neg_q ? -work_q : work_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mag_d   = mag_q;
        dvd_d   = dvd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (acc && is_mul) begin
                    state_d = S_MUL;
                    cnt_d   = '0;
                    work_d  = {{XLEN{1'b0}}, mag_b};
                    mag_d   = mag_a;
                    neg_d   = fwd_a[XLEN-1] ^ fwd_b[XLEN-1];
                end else if (acc && is_div) begin
                    state_d = S_DIV;
                    cnt_d   = '0;
                    work_d  = {{XLEN{1'b0}}, mag_a};
                    mag_d   = mag_b;
                    dvd_d   = fwd_a;
                    neg_d   = fwd_a[XLEN-1] ^ fwd_b[XLEN-1];
                end
            end
            S_MUL: begin
                if (cnt_q != CW'(XLEN)) begin
                    work_d = {mul_sum, work_q[XLEN-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    hi_d    = prod_s[2*XLEN-1:XLEN];
                    lo_d    = prod_s[XLEN-1:0];
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                if (cnt_q != CW'(XLEN)) begin
                    work_d = {rem_n, work_q[XLEN-2:0], ~div_sub[XLEN]};
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    if (mag_q == '0) begin
                        hi_d = dvd_q;
                        lo_d = '1;
                    end else begin
                        lo_d = neg_q ? -work_q[XLEN-1:0]
                                     : work_q[XLEN-1:0];
                        hi_d = dvd_q[XLEN-1]
                             ? -work_q[2*XLEN-1:XLEN]
                             : work_q[2*XLEN-1:XLEN];
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mag_q   <= '0;
            dvd_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mag_q   <= mag_d;
            dvd_q   <= dvd_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign io.busy = (state_q != S_IDLE);
    assign hi_rd   = hi_q;
    assign lo_rd   = lo_q;
`else
    assign ready   = 1'b1;
    assign io.busy = 1'b0;
    assign hi_rd   = '0;
    assign lo_rd   = '0;
`endif

    assign io.in_ready = ready;

    // mult/div retire into HI/LO only, so they load a bubble here
    always_ff @(posedge clk) begin
        if (rst || !acc || mdu_op) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            st_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mtr_q   <= 1'b0;
            mw_q    <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            res_q   <= alu_res;
            st_q    <= fwd_b;
            rd_q    <= dst;
            rw_q    <= reg_wr;
            mr_q    <= mem_rd;
            mtr_q   <= mem_to_reg;
            mw_q    <= mem_wr;
            zero_q  <= (alu_res == '0);
            ovf_q   <= alu_ovf;
        end
    end

    assign io.out_valid      = valid_q;
    assign io.out_result     = res_q;
    assign io.out_store_data = st_q;
    assign io.out_rd         = rd_q;
    assign io.out_reg_write  = rw_q;
    assign io.out_mem_read   = mr_q;
    assign io.out_mem_to_reg = mtr_q;
    assign io.out_mem_write  = mw_q;
    assign io.out_zero       = zero_q;
    assign io.out_ovf        = ovf_q;
endmodule

// File: tb/tb_exec_stage_mdu.sv
// tb_exec_stage_mdu: vector table + scoreboard for exec_stage_mdu,
// with hand-written mult/div/reset sequences.
module tb_exec_stage_mdu;
    localparam int NV = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    exec_stage_mdu_if #(.XLEN(32), .RADDR_W(5)) bus ();

    exec_stage_mdu #(.XLEN(32), .RADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        vld;
        logic [31:0] ins, a, b, imm;
        logic [7:0]  c;
        logic        ww;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        ev;
        logic [31:0] er, es;
        logic [4:0]  ed;
        logic [3:0]  ec;   // {reg_write, mem_read, mem_to_reg, mem_write}
        logic        eo;
    } vec_t;

    vec_t tbl [NV];
    vec_t sb [$];

    function automatic logic [31:0] rt_i(int s, int t, int d,
                                         int sh, int fn);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] it_i(int s, int t);
        return {6'h08, 5'(s), 5'(t), 16'h0};
    endfunction

    function automatic vec_t mk(int id, logic [31:0] ins,
            logic [31:0] a, logic [31:0] b, logic [31:0] imm,
            logic [7:0] c, logic ww, logic [4:0] wr, logic [31:0] wd,
            logic ev, logic [31:0] er, logic [31:0] es,
            logic [4:0] ed, logic [3:0] ec, logic eo);
        vec_t v;
        v.id = id;  v.vld = 1'b1; v.ins = ins; v.a = a; v.b = b;
        v.imm = imm; v.c = c; v.ww = ww; v.wr = wr; v.wd = wd;
        v.ev = ev; v.er = er; v.es = es; v.ed = ed; v.ec = ec;
        v.eo = eo;
        return v;
    endfunction

    // mult/div: accepted but no EX/MEM output
    function automatic vec_t mdu(int id, int fn, logic [31:0] a,
                                 logic [31:0] b);
        return mk(id, rt_i(1, 2, 0, 0, fn), a, b, 0, 8'h91,
                  0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    endfunction

    // mfhi/mflo into $2
    function automatic vec_t mv(int id, int fn, logic [31:0] e);
        return mk(id, rt_i(0, 0, 2, 0, fn), 0, 0, 0, 8'h91,
                  0, 0, 0, 1, e, 0, 2, 4'b1000, 0);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        int   w;
        vec_t e;
        @(negedge clk);
        bus.instr        = v.ins;
        bus.rs_data      = v.a;
        bus.rt_data      = v.b;
        bus.imm_ext      = v.imm;
        bus.ctrl         = v.c;
        bus.wb_reg_write = v.ww;
        bus.wb_rd        = v.wr;
        bus.wb_data      = v.wd;
        bus.in_valid     = v.vld;
        w = 0;
        while (v.vld && !bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            nchk++;
            nerr++;
            $display("FAIL v%0d.accept: in_ready never rose", v.id);
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d.valid", e.id), bus.out_valid, e.ev);
        chk($sformatf("v%0d.ctrl", e.id),
            {bus.out_reg_write, bus.out_mem_read,
             bus.out_mem_to_reg, bus.out_mem_write},
            e.ev ? e.ec : 4'b0000);
        if (e.ev) begin
            chk($sformatf("v%0d.result", e.id), bus.out_result, e.er);
            chk($sformatf("v%0d.store", e.id),
                bus.out_store_data, e.es);
            chk($sformatf("v%0d.rd", e.id), bus.out_rd, e.ed);
            chk($sformatf("v%0d.zero", e.id), bus.out_zero, e.er == 0);
            chk($sformatf("v%0d.ovf", e.id), bus.out_ovf, e.eo);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int nb;
        // id instr rs rt imm ctrl wbw wbrd wbd | ev res store rd ctl ovf
        tbl[0]  = mk(0, 32'h02538820, 5, 7, 0, 8'h91, 0, 0, 0,
                     1, 12, 7, 17, 4'b1000, 0);
        tbl[1]  = mk(1, rt_i(17, 18, 19, 0, 'h20), 99, 3, 0, 8'h91,
                     1, 17, 165189, 1, 15, 3, 19, 4'b1000, 0);
        tbl[2]  = mk(2, rt_i(17, 18, 19, 0, 'h20), 99, 3, 0, 8'h91,
                     1, 17, 165189, 1, 165192, 3, 19, 4'b1000, 0);
        tbl[3]  = mk(3, rt_i(3, 4, 0, 0, 'h20), 10, 20, 0, 8'h91,
                     0, 0, 0, 1, 30, 20, 0, 4'b1000, 0);
        tbl[4]  = mk(4, rt_i(0, 6, 5, 0, 'h20), 0, 4, 0, 8'h91,
                     1, 0, 777, 1, 4, 4, 5, 4'b1000, 0);
        tbl[5]  = mk(5, rt_i(7, 8, 6, 0, 'h20), 32'h7FFFFFFF, 1, 0,
                     8'h91, 0, 0, 0, 1, 32'h80000000, 1, 6, 4'b1000, 1);
        tbl[6]  = mk(6, rt_i(7, 8, 9, 0, 'h24), 32'h7FFFFFFF,
                     32'h80000000, 0, 8'h91, 0, 0, 0,
                     1, 0, 32'h80000000, 9, 4'b1000, 0);
        tbl[7]  = mk(7, rt_i(11, 12, 10, 0, 'h2A), 32'hFFFFFFFF, 1, 0,
                     8'h91, 0, 0, 0, 1, 1, 1, 10, 4'b1000, 0);
        tbl[8]  = mk(8, rt_i(11, 12, 13, 0, 'h22), 32'h80000000, 1, 0,
                     8'h91, 0, 0, 0, 1, 32'h7FFFFFFF, 1, 13, 4'b1000, 1);
        tbl[9]  = mk(9, rt_i(11, 12, 14, 0, 'h25), 32'hF0, 32'h0F, 0,
                     8'h91, 0, 0, 0, 1, 32'hFF, 32'h0F, 14, 4'b1000, 0);
        tbl[10] = mk(10, rt_i(11, 12, 15, 0, 'h27), 32'hF0F0F0F0,
                     32'h0F0F0F00, 0, 8'h91, 0, 0, 0,
                     1, 32'h0000000F, 32'h0F0F0F00, 15, 4'b1000, 0);
        tbl[11] = mk(11, rt_i(0, 12, 16, 4, 'h00), 0, 32'h12345678, 0,
                     8'h91, 0, 0, 0, 1, 32'h23456780, 32'h12345678,
                     16, 4'b1000, 0);
        tbl[12] = mk(12, rt_i(0, 12, 20, 8, 'h02), 0, 32'h80000000, 0,
                     8'h91, 0, 0, 0, 1, 32'h00800000, 32'h80000000,
                     20, 4'b1000, 0);
        tbl[13] = mk(13, it_i(21, 22), 32'h1000, 0, 32'hFFFFFFFC,
                     8'h27, 0, 0, 0, 1, 32'h0FFC, 0, 22, 4'b1110, 0);
        tbl[14] = mk(14, it_i(23, 22), 32'h2000, 32'hCAFE, 8, 8'h42,
                     0, 0, 0, 1, 32'h2008, 32'h0FFC, 22, 4'b0001, 0);
        tbl[15] = mk(15, it_i(25, 26), 5, 5, 0, 8'h08, 0, 0, 0,
                     1, 0, 5, 26, 4'b0000, 0);
        tbl[16] = mk(16, rt_i(1, 2, 3, 0, 'h3F), 9, 9, 0, 8'h91,
                     0, 0, 0, 1, 0, 9, 3, 4'b1000, 0);
        tbl[17] = mk(17, rt_i(28, 29, 27, 0, 'h20), 1, 2, 0, 8'h91,
                     1, 29, 40, 1, 41, 40, 27, 4'b1000, 0);
        tbl[18] = mk(18, it_i(31, 30), 32'h7FFFFFFF, 0, 1, 8'h03,
                     0, 0, 0, 1, 32'h80000000, 0, 30, 4'b1000, 1);
        tbl[19] = mk(19, rt_i(1, 2, 3, 0, 'h20), 1, 1, 0, 8'h91,
                     0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        tbl[19].vld = 1'b0;

        bus.in_valid     = 1'b0;
        bus.instr        = '0;
        bus.rs_data      = '0;
        bus.rt_data      = '0;
        bus.imm_ext      = '0;
        bus.ctrl         = '0;
        bus.wb_reg_write = 1'b0;
        bus.wb_rd        = '0;
        bus.wb_data      = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", bus.out_valid, 0);
        chk("rst.ready", bus.in_ready, 1);
        chk("rst.busy", bus.busy, 0);
        chk("rst.result", bus.out_result, 0);
        chk("rst.rd", bus.out_rd, 0);
        chk("rst.reg_write", bus.out_reg_write, 0);
        chk("rst.ovf", bus.out_ovf, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) issue(tbl[i]);

`ifdef EXEC_MDU_EN
        // mult -3 * 7: stall length, then read HI/LO
        issue(mdu(100, 'h18, 32'hFFFFFFFD, 7));
        chk("mult.busy", bus.busy, 1);
        cnt = 0;
        nb  = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            cnt++;
            if (bus.busy) nb++;
        end
        chk("mult.stall_cycles", cnt, 33);
        chk("mult.busy_cycles", nb, 33);
        issue(mv(101, 'h12, 32'hFFFFFFEB));
        issue(mv(102, 'h10, 32'hFFFFFFFF));

        // reset part way through a divide
        issue(mdu(110, 'h1A, 100, 3));
        repeat (10) @(negedge clk);
        chk("rstmid.busy_before", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid.busy", bus.busy, 0);
        chk("rstmid.ready", bus.in_ready, 1);
        rst = 1'b0;
        issue(mv(111, 'h10, 0));
        issue(mv(112, 'h12, 0));

        // mfhi/mflo held upstream until the divide retires
        issue(mdu(120, 'h1A, 32'hFFFFFFF9, 2));
        issue(mv(121, 'h12, 32'hFFFFFFFD));
        issue(mv(122, 'h10, 32'hFFFFFFFF));
        issue(mdu(130, 'h1A, 9, 0));
        issue(mv(131, 'h10, 9));
        issue(mv(132, 'h12, 32'hFFFFFFFF));
        issue(mdu(140, 'h1A, 32'h80000000, 32'hFFFFFFFF));
        issue(mv(141, 'h12, 32'h80000000));
        issue(mv(142, 'h10, 0));
        issue(mdu(150, 'h18, 32'h80000000, 32'hFFFFFFFF));
        issue(mv(151, 'h10, 0));
        issue(mv(152, 'h12, 32'h80000000));
`else
        issue(mdu(200, 'h18, 32'hFFFFFFFD, 7));
        cnt = 0;
        nb  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (!bus.in_ready) cnt++;
        end
        chk("nomdu.busy_cycles", nb, 0);
        chk("nomdu.stall_cycles", cnt, 0);
        issue(mdu(201, 'h1A, 9, 0));
        issue(mv(202, 'h10, 0));
        issue(mv(203, 'h12, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end
endmodule

// File: doc/exec_stage_mdu.md
# exec_stage_mdu

Parametrised execute stage for the pipelined MIPS core, sitting between the ID/EX and EX/MEM pipeline registers. It extends the single-cycle ALU stage with two-level operand forwarding, configurable datapath width, and registered EX/MEM outputs with valid qualification. It also adds an iterative signed multiply/divide unit (HI/LO registers, mfhi/mflo) that stalls the front end through a ready handshake while it runs.

## Interface
- XLEN, 32: datapath width; must be ≥8 and even.
- RADDR_W, 5: register-address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ID/EX slot holds a valid instruction.
- in_ready  out  1  stage can accept this cycle; combinational from FSM state.
- instr  in  32  instruction word; funct[5:0], shamt[10:6], rd[15:11], rt[20:16], rs[25:21].
- rs_data, rt_data  in  XLEN  register-file read values.
- imm_ext  in  XLEN  sign-extended immediate.
- ctrl  in  8  {RegDst, MemWrite, MemToReg, ALUOp[1:0], MemRead, ALUSrc, RegWrite}, bit 7 down to bit 0.
- wb_reg_write  in  1  MEM/WB RegWrite.
- wb_rd  in  RADDR_W  MEM/WB destination.
- wb_data  in  XLEN  MEM/WB result.
- out_valid  out  1  EX/MEM slot valid.
- out_result  out  XLEN  ALU or HI/LO result.
- out_store_data  out  XLEN  forwarded rt value, for sw.
- out_rd  out  RADDR_W  destination register.
- out_reg_write, out_mem_read, out_mem_to_reg, out_mem_write  out  1 each  control bits passed through.
- out_zero, out_ovf  out  1 each  ALU zero flag and signed-overflow flag.
- busy  out  1  MDU iterating.

## Operation
- Accept: in_valid & in_ready. A cycle without acceptance loads a bubble: out_valid=0 and all out_* control bits 0.
- Forwarding, evaluated for rs and rt separately: EX/MEM source if out_valid & out_reg_write & out_rd≠0 & out_rd==src. Otherwise MEM/WB source if wb_reg_write & wb_rd≠0 & wb_rd==src. Otherwise register-file value. EX/MEM has priority.
- Operand B: imm_ext if ALUSrc, else forwarded rt.
- Destination: rd if RegDst, else rt.
- ALUOp 00: add. 01: sub. 10: decode funct:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed, result 0/1).
  - 0x00 sll by shamt, 0x02 srl by shamt.
  - 0x10 mfhi, 0x12 mflo.
  - 0x18 mult, 0x1A div.
  - Any other funct: result 0.
- out_ovf is 1 only for add or sub with signed overflow. The result still wraps modulo 2^XLEN.
- out_zero = (result==0).
- mult/div: signed, forwarded rs/rt operands captured at accept. The instruction retires into HI/LO only; it produces no EX/MEM output (out_valid=0).
- MDU FSM states:
  - IDLE: in_ready=1. Accepted mult → MUL; accepted div → DIV; counter=0.
  - MUL/DIV: in_ready=0, busy=1. One shift-add or restoring-subtract step per cycle on operand magnitudes. After XLEN steps, apply signs, write HI/LO, return to IDLE.
- mult: {HI,LO} = full 2·XLEN-bit signed product.
- div: LO = quotient truncated toward zero; HI = remainder, carrying the dividend's sign.
- Div by zero: HI=dividend, LO=all ones.
- MIN/−1: LO=MIN, HI=0.
- Both special cases still take XLEN cycles.

## Timing
- ALU instructions: 1-cycle latency; result registered at the edge that accepts the instruction. Back-to-back accepts allowed.
- mult/div accepted at edge T:
  - busy=1 and in_ready=0 from T through T+XLEN.
  - HI/LO updated at edge T+XLEN+1, together with the return to IDLE.
  - in_ready=1 in the following cycle.
- mfhi/mflo immediately after mult/div is held upstream by in_ready and reads the final HI/LO.
- in_valid while busy: ignored, no state change; upstream must hold inputs.
- Reset values: all out_* = 0, busy=0, in_ready=1, HI=LO=0, FSM=IDLE, counter=0.
- rst mid-iteration: aborts the operation and clears HI/LO. rst has priority over accept.

## Configuration
- EXEC_MDU_EN defined: MDU, HI/LO, mfhi/mflo and the stall behaviour as above.
- EXEC_MDU_EN undefined: no MDU logic or HI/LO storage. mult/div execute as single-cycle bubbles with no effect, mfhi/mflo return 0, busy tied 0, in_ready tied 1.

## Test plan
- add $s1,$s2,$s3 (instr 0x02538820), rs=5, rt=7, ctrl=0x91 → next edge: out_valid=1, result=12, out_rd=17, out_reg_write=1.
- Forwarding priority:
  - Add into $s1 (result 12), then add $s3,$s1,$s2 with wb_rd=17, wb_data=165189 → operand A=12 (EX/MEM wins).
  - With EX/MEM not matching → operand A=165189.
  - rd=0 is never forwarded.
- Overflow: add 0x7FFFFFFF+1 → result 0x80000000, out_ovf=1; and/slt produce out_ovf=0.
- mult −3×7 (XLEN=32) → in_ready low for 33 cycles; following mflo gives 0xFFFFFFEB, mfhi gives 0xFFFFFFFF.
- div −7/2 → LO=−3, HI=−1. div 9/0 → HI=9, LO=0xFFFFFFFF. div 0x80000000/−1 → LO=0x80000000, HI=0.
- rst asserted 10 cycles into a div → next cycle busy=0, in_ready=1, HI=LO=0. With EXEC_MDU_EN undefined, mult → busy never asserts, out_valid=0.
